pixel_readout: RTL and testbench
================================

# pixel_readout

Downstream stage of the pixel-array control state machine. Consumes its `convert`, `read1` and `read2` phase signals, and drives the ramp counter that pixels latch during conversion. During each read phase it selects a row, captures one row of pixel codes after a settle delay, and streams the codes out one word per transfer through a valid/ready FIFO. A row that does not fit in the FIFO is dropped and flagged.

## Interface
Parameters:
- `DATA_W`, 8: pixel code / ramp width
- `NUM_COLS`, 2: pixels per row
- `FIFO_DEPTH`, 4: output FIFO depth in words; must be ≥ `NUM_COLS`
- `SETTLE`, 2: cycles a read phase must be high before capture; must be ≥ 1

Ports:
- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `convert` in 1: conversion phase from the control FSM
- `read1` in 1: row-1 read phase
- `read2` in 1: row-2 read phase
- `pix_data` in `NUM_COLS*DATA_W`: row bus; column c occupies `[c*DATA_W +: DATA_W]`
- `adc_count` out `DATA_W`: ramp code to the pixel array
- `row_sel` out 2: registered row enables; bit0 is row 1, bit1 is row 2
- `out_data` out `DATA_W`: FIFO head word
- `out_valid` out 1: FIFO non-empty
- `out_ready` in 1: consumer accepts `out_data`
- `overflow` out 1: sticky row-dropped flag

## Operation
- Reset values: `adc_count`=0, `row_sel`=0, `out_valid`=0, `out_data`=0, `overflow`=0, FIFO empty, state IDLE.
- FSM states and transitions:
  - IDLE → CONV on `convert`.
  - IDLE → READ on `read1` or `read2`.
  - CONV → IDLE when `convert` falls.
  - READ → IDLE when the active read signal falls.
- Ramp counter:
  - On the edge where `convert` is first sampled high, `adc_count` loads 0.
  - On each further edge with `convert` high, it increments by 1 and saturates at 2^`DATA_W`−1.
  - It holds its value outside CONV.
- Read phase:
  - `row_sel` follows `{read2, read1}` delayed one cycle.
  - If both reads are high, `read1` wins and `row_sel`=01.
- Settle and capture:
  - A settle counter counts edges with the active read high.
  - On the `SETTLE`-th edge, the full `pix_data` row is captured once per phase.
  - If the read falls earlier, nothing is captured.
- Capture into the FIFO:
  - If free space ≥ `NUM_COLS`, all columns are written in a single edge, column 0 first in output order.
  - Otherwise the whole row is dropped and `overflow` is set to 1. `overflow` clears only on reset.
  - Free space is evaluated before a same-edge pop.
- Output handshake:
  - A word transfers on an edge with `out_valid && out_ready`.
  - `out_data` must stay stable while `out_valid && !out_ready`.
  - A simultaneous push and pop is legal.
- `convert` is ignored while in READ, and reads are ignored while in CONV.
- Reset asserted mid-phase aborts immediately and discards FIFO contents.

## Timing
- Ramp: `adc_count`=k on the k-th edge after the load edge.
- `row_sel` is asserted one cycle after the read rises.
- Capture latency: `out_valid` rises in the cycle after the capture edge. With `SETTLE`=2 this is 2 cycles after the read rises.
- Throughput is one word per cycle when `out_ready`=1.

## Configuration
- `PIXEL_READOUT_GRAY_EN` defined: `adc_count` outputs the Gray code of the internal binary counter, i.e. bin ^ (bin >> 1). Saturation still applies to the binary value.
- Not defined: `adc_count` is plain binary.

## Structure
- Package `pixel_readout_pkg`: FSM state enum (IDLE, CONV, READ) and default width/depth constants.
- Sub-module `readout_fifo`:
  - row-wide write port and single-word read port;
  - exposes `free` count, `empty` flag and head word.

## Test plan
Defaults for all scenarios: `DATA_W`=8, `NUM_COLS`=2, `FIFO_DEPTH`=4, `SETTLE`=2.
- Convert for 10 cycles → `adc_count` goes 0…9 and holds 9; convert for 300 cycles → saturates at 255.
- `read1` for 4 cycles with `pix_data`=16'hB2A1 and `out_ready`=1:
  - `row_sel`=01 one cycle after the rise;
  - output A1 then B2;
  - `overflow`=0.
- `read2` high for 1 cycle → `row_sel` pulses 10; no capture; `out_valid` stays 0.
- `out_ready`=0, then `read1` (16'h2211), `read2` (16'h4433), `read1` (16'h6655):
  - FIFO holds 11, 22, 33, 44; third row is dropped; `overflow`=1.
  - Then `out_ready`=1 → 11, 22, 33, 44 in order.
- `reset` pulsed mid-convert at count 5 with 2 words queued → all outputs return to reset values immediately.
- With `PIXEL_READOUT_GRAY_EN`, convert 4 edges (binary 3) → `adc_count`=2; at 255 → `adc_count`=128.

Source files
------------

// File: rtl/pixel_readout_pkg.sv
// Shared types and default sizing for the pixel readout stage.
package pixel_readout_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StRead = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_NUM_COLS   = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_SETTLE     = 2;

endpackage

// File: rtl/readout_fifo.sv
// Word FIFO with a row-wide write port (NUM_COLS words per push, column 0 first) and a
// single-word read port. Exposes free space, empty flag and the head word.
module readout_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_COLS = 2,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [NUM_COLS*DATA_W-1:0] wr_row,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       empty,
    output logic [CNT_W-1:0]           free
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] add_wrap(input logic [PTR_W-1:0] p,
                                                  input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    assign empty  = (count == '0);
    assign free   = CNT_W'(DEPTH) - count;
    assign pop_ok = pop && !empty;
    // Gate the head so an empty FIFO never shows stale storage.
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                mem[add_wrap(wr_ptr, c)] <= wr_row[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= add_wrap(wr_ptr, NUM_COLS);
            if (pop_ok) rd_ptr <= add_wrap(rd_ptr, 1);
            count <= count + (push ? CNT_W'(NUM_COLS) : CNT_W'(0))
                           - (pop_ok ? CNT_W'(1) : CNT_W'(0));
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Pixel-array readout: ramp counter during convert, row select/settle/capture during reads,
// and a valid/ready word FIFO. Define PIXEL_READOUT_GRAY_EN to emit the ramp as Gray code.
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_COLS   = DEF_NUM_COLS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned SETTLE     = DEF_SETTLE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       convert,
    input  logic                       read1,
    input  logic                       read2,
    input  logic [NUM_COLS*DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0]          adc_count,
    output logic [1:0]                 row_sel,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(SETTLE + 1);
    localparam logic [ST_W-1:0] SETTLE_C = ST_W'(SETTLE);

    state_t            state;
    logic [DATA_W-1:0] bin_count;
    logic              active_r2;
    logic [ST_W-1:0]   settle_cnt;
    logic              active_high;
    logic              capture;
    logic              room;
    logic              push;
    logic              empty;
    logic [CNT_W-1:0]  free;

    assign active_high = active_r2 ? read2 : read1;
    assign room        = (free >= CNT_W'(NUM_COLS));
    assign push        = capture && room;
    assign out_valid   = !empty;

    always_comb begin
        capture = 1'b0;
        unique case (state)
            StIdle:  capture = !convert && (read1 || read2) && (SETTLE == 1);
            // settle_cnt saturates at SETTLE, so this fires once per phase.
            StRead:  capture = active_high && (settle_cnt < SETTLE_C)
                               && (settle_cnt + ST_W'(1) == SETTLE_C);
            default: capture = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            bin_count  <= '0;
            row_sel    <= 2'b00;
            active_r2  <= 1'b0;
            settle_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (capture && !room) overflow <= 1'b1;
            unique case (state)
                StIdle: begin
                    if (convert) begin
                        state     <= StConv;
                        bin_count <= '0;
                    end else if (read1 || read2) begin
                        state      <= StRead;
                        active_r2  <= !read1;
                        row_sel    <= read1 ? 2'b01 : 2'b10;
                        settle_cnt <= ST_W'(1);
                    end
                end
                StConv: begin
                    if (!convert) begin
                        state <= StIdle;
                    end else if (bin_count != '1) begin
                        bin_count <= bin_count + DATA_W'(1);
                    end
                end
                StRead: begin
                    if (!active_high) begin
                        state   <= StIdle;
                        row_sel <= 2'b00;
                    end else if (settle_cnt < SETTLE_C) begin
                        settle_cnt <= settle_cnt + ST_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef PIXEL_READOUT_GRAY_EN
    assign adc_count = bin_count ^ (bin_count >> 1);
`else
    assign adc_count = bin_count;
`endif

    readout_fifo #(
        .DATA_W   (DATA_W),
        .NUM_COLS (NUM_COLS),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wr_row (pix_data),
        .pop    (out_ready),
        .head   (out_data),
        .empty  (empty),
        .free   (free)
    );

endmodule

// File: tb/tb_pixel_readout.sv
// Randomized and directed bench for pixel_readout against a phase-level reference model.
module tb_pixel_readout;

    localparam int DATA_W     = 8;
    localparam int NUM_COLS   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SETTLE     = 2;
    localparam int RAMP_MAX   = (1 << DATA_W) - 1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       convert = 1'b0;
    logic                       read1 = 1'b0;
    logic                       read2 = 1'b0;
    logic [NUM_COLS*DATA_W-1:0] pix_data = '0;
    logic                       out_ready = 1'b0;
    logic [DATA_W-1:0]          adc_count;
    logic [1:0]                 row_sel;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 converting, 2 reading.
    int                m_phase;
    int                m_ramp;
    int                m_row;
    int                m_high;
    int                m_rowsel;
    bit                m_ovf;
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] xfer[$];

    pixel_readout #(
        .DATA_W     (DATA_W),
        .NUM_COLS   (NUM_COLS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SETTLE     (SETTLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .convert   (convert),
        .read1     (read1),
        .read2     (read2),
        .pix_data  (pix_data),
        .adc_count (adc_count),
        .row_sel   (row_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ramp_out(input int b);
        logic [DATA_W-1:0] v;
        v = DATA_W'(b);
`ifdef PIXEL_READOUT_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic void model_clear();
        m_phase  = 0;
        m_ramp   = 0;
        m_row    = 0;
        m_high   = 0;
        m_rowsel = 0;
        m_ovf    = 0;
        m_q.delete();
    endfunction

    function automatic void model_edge(input bit cv, input bit r1, input bit r2,
                                       input logic [NUM_COLS*DATA_W-1:0] pix, input bit rdy);
        int free;
        bit pop;
        bit cap;
        bit act;
        free = FIFO_DEPTH - m_q.size();
        pop  = (m_q.size() != 0) && rdy;
        cap  = 0;
        if (m_phase == 0) begin
            if (cv) begin
                m_phase = 1;
                m_ramp  = 0;
            end else if (r1 || r2) begin
                m_phase  = 2;
                m_row    = r1 ? 1 : 2;
                m_rowsel = m_row;
                m_high   = 1;
                cap      = (SETTLE == 1);
            end
        end else if (m_phase == 1) begin
            if (cv) m_ramp = (m_ramp < RAMP_MAX) ? m_ramp + 1 : RAMP_MAX;
            else m_phase = 0;
        end else begin
            act = (m_row == 1) ? r1 : r2;
            if (act) begin
                m_high++;
                cap = (m_high == SETTLE);
            end else begin
                m_phase  = 0;
                m_rowsel = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (free >= NUM_COLS) begin
                for (int c = 0; c < NUM_COLS; c++) m_q.push_back(pix[c*DATA_W +: DATA_W]);
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, "_adc"}, 32'(adc_count), 32'(ramp_out(m_ramp)));
        check_eq({tag, "_rowsel"}, 32'(row_sel), 32'(m_rowsel));
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq({tag, "_data"}, 32'(out_data), 32'(m_q[0]));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: apply inputs, log any transfer, advance model, check #1 after the edge.
    task automatic step(input bit cv, input bit r1, input bit r2,
                        input logic [NUM_COLS*DATA_W-1:0] pix, input bit rdy, input string tag);
        convert   = cv;
        read1     = r1;
        read2     = r2;
        pix_data  = pix;
        out_ready = rdy;
        if (out_valid && out_ready) xfer.push_back(out_data);
        @(posedge clk);
        model_edge(cv, r1, r2, pix, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        convert   = 0;
        read1     = 0;
        read2     = 0;
        out_ready = 0;
        reset     = 1;
        #1;
        model_clear();
        check_all(tag);
        check_eq({tag, "_data0"}, 32'(out_data), 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
        xfer.delete();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset");

        // Ramp: 10 convert edges give 0..9, then hold.
        for (int i = 0; i < 10; i++) step(1, 0, 0, '0, 0, "conv10");
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, "conv_hold");
        check_eq("ramp_hold9", 32'(adc_count), 32'(ramp_out(9)));
        for (int i = 0; i < 300; i++) step(1, 0, 0, '0, 0, "conv300");
        check_eq("ramp_sat", 32'(adc_count), 32'(ramp_out(RAMP_MAX)));
        step(0, 0, 0, '0, 0, "conv_end");

        // Single read1 row with ready held high.
        do_reset("reset2");
        step(0, 1, 0, 16'hB2A1, 1, "rd1");
        check_eq("rowsel_rise", 32'(row_sel), 32'h1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'hB2A1, 1, "rd1");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0000, 1, "rd1_drain");
        check_eq("rd1_nwords", 32'(xfer.size()), 32'd2);
        if (xfer.size() == 2) begin
            check_eq("rd1_w0", 32'(xfer[0]), 32'hA1);
            check_eq("rd1_w1", 32'(xfer[1]), 32'hB2);
        end
        check_eq("rd1_ovf", 32'(overflow), 32'h0);

        // One-cycle read2: row_sel pulses, nothing captured.
        step(0, 0, 1, 16'h5A5A, 1, "rd2_short");
        check_eq("rd2_rowsel", 32'(row_sel), 32'h2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0000, 1, "rd2_after");
        check_eq("rd2_novalid", 32'(out_valid), 32'h0);
        check_eq("rd2_rowsel_off", 32'(row_sel), 32'h0);

        // Fill with ready low; the third row must be dropped.
        xfer.delete();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h2211, 0, "fill_a");
        step(0, 0, 0, '0, 0, "fill_gap");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h4433, 0, "fill_b");
        step(0, 0, 0, '0, 0, "fill_gap");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h6655, 0, "fill_c");
        step(0, 0, 0, '0, 0, "fill_gap");
        check_eq("fill_ovf", 32'(overflow), 32'h1);
        check_eq("fill_head", 32'(out_data), 32'h11);
        for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1, "fill_drain");
        check_eq("fill_nwords", 32'(xfer.size()), 32'd4);
        if (xfer.size() == 4) begin
            check_eq("fill_w0", 32'(xfer[0]), 32'h11);
            check_eq("fill_w1", 32'(xfer[1]), 32'h22);
            check_eq("fill_w2", 32'(xfer[2]), 32'h33);
            check_eq("fill_w3", 32'(xfer[3]), 32'h44);
        end

        // Reset mid-convert with two words queued.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'hBBAA, 0, "mid_rd");
        step(0, 0, 0, '0, 0, "mid_gap");
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0, 0, "mid_conv");
        check_eq("mid_count5", 32'(adc_count), 32'(ramp_out(5)));
        check_eq("mid_queued", 32'(out_valid), 32'h1);
        do_reset("mid_reset");

        // Randomized phase sequences with random back-pressure.
        for (int seg = 0; seg < 200; seg++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, 6);
            if (kind == 5 && $urandom_range(0, 9) == 0) begin
                do_reset("rnd_reset");
            end else begin
                for (int i = 0; i < len; i++) begin
                    bit rdy;
                    rdy = ($urandom_range(0, 9) < 6);
                    case (kind)
                        1:       step(1, 0, 0, 16'($urandom), rdy, "rnd_conv");
                        2:       step(0, 1, 0, 16'($urandom), rdy, "rnd_rd1");
                        3:       step(0, 0, 1, 16'($urandom), rdy, "rnd_rd2");
                        4:       step(0, 1, 1, 16'($urandom), rdy, "rnd_rd12");
                        default: step(0, 0, 0, 16'($urandom), rdy, "rnd_idle");
                    endcase
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
